mux_scan: RTL and testbench
===========================

# mux_scan

Parametrised, registered N-channel multiplexer, the successor to the combinational 4:1 mux. It runs in two modes. In manual mode the external `sel` picks the channel. In scan mode an internal pointer sweeps all channels round-robin, holding each one for a programmable number of cycles. Downstream sampling logic consumes the output as a time-division stream, using valid, channel-tag and wrap markers.

## Interface
- `N`, default 4: number of input channels; 2 ≤ N ≤ 256, need not be a power of two.
- `W`, default 1: data width per channel.
- `HOLD`, default 1: cycles each channel is presented in scan mode; HOLD ≥ 1.
- `SW`, derived `$clog2(N)`: select/tag width; not user-overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  N*W  packed channels; channel k is `din[k*W +: W]`.
- `mode`  in  1  0 = manual select, 1 = auto scan.
- `sel`  in  SW  channel index used in manual mode.
- `en`  in  1  advance/sample enable; 0 pauses the block.
- `dout`  out  W  registered selected data.
- `dout_sel`  out  SW  channel index that `dout` came from.
- `dout_vld`  out  1  `dout` holds a fresh sample this cycle.
- `wrap`  out  1  one-cycle pulse marking the last scan sample of channel N-1.

## Operation
- Reset (`rst_n`=0, asynchronous): `dout`=0, `dout_sel`=0, `dout_vld`=0, `wrap`=0, scan pointer `ch`=0, hold counter `hcnt`=0.
  - Reset asserted mid-scan clears everything immediately.
  - First scan sample after release is always channel 0.
- Manual mode (`mode`=0):
  - `ch` and `hcnt` are forced to 0 every cycle.
  - `en`=1 and `sel` < N: `dout`←channel `sel`, `dout_sel`←`sel`, `dout_vld`←1.
  - `en`=1 and `sel` ≥ N (non-power-of-two N): `dout` and `dout_sel` hold, `dout_vld`←0.
  - `en`=0: `dout` and `dout_sel` hold, `dout_vld`←0.
  - `wrap` is always 0.
- Scan mode (`mode`=1), `en`=1:
  - `dout`←channel `ch`, `dout_sel`←`ch`, `dout_vld`←1.
  - If `hcnt`==HOLD-1: `hcnt`←0 and `ch`←(`ch`==N-1 ? 0 : `ch`+1).
  - Otherwise `hcnt`←`hcnt`+1.
  - `wrap`←1 exactly when the sample being registered is channel N-1 with `hcnt`==HOLD-1; otherwise `wrap`←0.
- Scan mode, `en`=0:
  - `ch` and `hcnt` are frozen.
  - `dout` and `dout_sel` hold.
  - `dout_vld`←0 and `wrap`←0.
- Mode change:
  - 1→0: the scan position is discarded.
  - 0→1: the scan starts at channel 0 with a full HOLD period, because `ch` and `hcnt` were already 0.
- `mode` is sampled on the same edge as `en`, so a mode change takes effect on that edge's output.
- `sel` is ignored in scan mode.
- `hcnt` width is `$clog2(HOLD)`, minimum 1. With HOLD=1 the pointer advances every enabled cycle.

## Timing
- Latency: one clock from `din`/`sel`/`mode`/`en` to `dout`/`dout_sel`/`dout_vld`/`wrap`. There is no combinational input-to-output path.
- `dout` changes only on edges where `dout_vld` is registered to 1.
- `din` need only be stable at the sampling edge; no skid or backpressure.
- Full scan period is N×HOLD enabled cycles, with exactly one `wrap` pulse per period.
- Pausing with `en`=0 stretches the period without losing or duplicating any sample slot.

## Test plan
- Reset and manual select (N=4, W=4, HOLD=2; `din`=16'hD5A3):
  - During reset, all outputs are 0.
  - After release, `mode`=0, `en`=1, `sel` stepped 0,1,2,3 on successive cycles.
  - Required: `dout`=3,A,5,D, each one cycle after its `sel`, with `dout_sel` matching and `dout_vld`=1 throughout.
- Scan sweep, same `din`, `mode`=1, `en`=1 for 10 cycles:
  - `dout_sel`=0,0,1,1,2,2,3,3,0,0.
  - `dout`=3,3,A,A,5,5,D,D,3,3.
  - `wrap`=1 only on the second channel-3 cycle.
- Pause mid-hold:
  - Deassert `en` after the first channel-1 sample.
  - Required while paused: `dout_vld`=0, `dout` holds A.
  - On re-enable: exactly one more channel-1 sample, then channel 2.
- Mode switch and reset mid-scan:
  - Switch to manual at channel 2, then back to scan: the next sample is channel 0 for 2 cycles.
  - Pulse `rst_n` low mid-scan: outputs clear asynchronously, before the next edge.
- Non-power-of-two N=3, HOLD=1:
  - Scan yields `dout_sel`=0,1,2,0 with `wrap` on the channel-2 sample.
  - Manual `sel`=3 gives `dout_vld`=0 and `dout` held.
- Randomised: `din` set by `{$random}` each cycle, random `mode`/`en`/`sel`.
  - Required: every `dout_vld`=1 output equals the reference model's channel value from the previous edge.

Source files
------------

// File: rtl/mux_scan_if.sv
// rtl/mux_scan_if.sv - channel inputs, controls and tagged output stream of mux_scan
interface mux_scan_if #(
   parameter int N = 4,
   parameter int W = 1
);
   localparam int SW = $clog2(N);

   logic [N*W-1:0] din;
   logic           mode;
   logic [SW-1:0]  sel;
   logic           en;
   logic [W-1:0]   dout;
   logic [SW-1:0]  dout_sel;
   logic           dout_vld;
   logic           wrap;

   modport master (
      output din, mode, sel, en,
      input  dout, dout_sel, dout_vld, wrap
   );

   modport slave (
      input  din, mode, sel, en,
      output dout, dout_sel, dout_vld, wrap
   );
endinterface

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - registered N-channel mux with manual select and round-robin scan
module mux_scan #(
   parameter int N    = 4,
   parameter int W    = 1,
   parameter int HOLD = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   mux_scan_if.slave  bus
);
   localparam int SW = $clog2(N);
   // hold counter keeps at least one bit so HOLD=1 still has a legal vector
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [SW-1:0] LAST_CH = SW'(N - 1);
   localparam logic [HW-1:0] LAST_H  = HW'(HOLD - 1);

   logic [SW-1:0] ch;
   logic [HW-1:0] hcnt;
   logic [W-1:0]  dout_q;
   logic [SW-1:0] dout_sel_q;
   logic          dout_vld_q;
   logic          wrap_q;

   logic [W-1:0]  sel_data;
   logic [W-1:0]  scan_data;
   logic          sel_ok;
   logic          hold_done;
   logic          period_end;

   // sel can exceed N-1 when N is not a power of two; such selects are dropped
   assign sel_ok     = (int'(bus.sel) < N);
   assign hold_done  = (hcnt == LAST_H);
   assign period_end = (ch == LAST_CH) && hold_done;

   // channel extraction for the manual select and the scan pointer
   always_comb begin
      sel_data  = '0;
      scan_data = '0;
      for (int k = 0; k < N; k++) begin
         if (bus.sel == SW'(k)) sel_data  = bus.din[k*W +: W];
         if (ch == SW'(k))      scan_data = bus.din[k*W +: W];
      end
   end

   // output register and scan pointer; manual mode parks the pointer at channel 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch         <= '0;
         hcnt       <= '0;
         dout_q     <= '0;
         dout_sel_q <= '0;
         dout_vld_q <= 1'b0;
         wrap_q     <= 1'b0;
      end else if (!bus.mode) begin
         ch     <= '0;
         hcnt   <= '0;
         wrap_q <= 1'b0;
         if (bus.en && sel_ok) begin
            dout_q     <= sel_data;
            dout_sel_q <= bus.sel;
            dout_vld_q <= 1'b1;
         end else begin
            dout_vld_q <= 1'b0;
         end
      end else if (bus.en) begin
         dout_q     <= scan_data;
         dout_sel_q <= ch;
         dout_vld_q <= 1'b1;
         wrap_q     <= period_end;
         if (hold_done) begin
            hcnt <= '0;
            ch   <= (ch == LAST_CH) ? '0 : ch + 1'b1;
         end else begin
            hcnt <= hcnt + 1'b1;
         end
      end else begin
         dout_vld_q <= 1'b0;
         wrap_q     <= 1'b0;
      end
   end

   assign bus.dout     = dout_q;
   assign bus.dout_sel = dout_sel_q;
   assign bus.dout_vld = dout_vld_q;
   assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - scoreboard bench for mux_scan, N=4/HOLD=2 and N=3/HOLD=1
module tb_mux_scan;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mux_scan_if #(.N(4), .W(4)) ifa ();
   mux_scan_if #(.N(3), .W(4)) ifb ();

   mux_scan #(.N(4), .W(4), .HOLD(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   mux_scan #(.N(3), .W(4), .HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   typedef struct {
      logic       vld;
      logic [3:0] dout;
      int         dsel;
      logic       wrap;
   } exp_t;

   typedef struct {
      logic [3:0] dout;
      int         dsel;
      int         pos;
   } ms_t;

   int   total = 0;
   int   bad   = 0;
   exp_t qa[$];
   exp_t qb[$];
   ms_t  sa;
   ms_t  sb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
      end
   endtask

   // pos counts enabled scan slots within one N*HOLD period
   task automatic model(input int n, input int hold, input logic md, input logic en,
                        input int sel, input logic [15:0] din, inout ms_t s, output exp_t e);
      int c;
      e.vld  = 1'b0;
      e.wrap = 1'b0;
      if (!md) begin
         s.pos = 0;
         if (en && sel < n) begin
            s.dout = din[sel*4 +: 4];
            s.dsel = sel;
            e.vld  = 1'b1;
         end
      end else if (en) begin
         c      = s.pos / hold;
         s.dout = din[c*4 +: 4];
         s.dsel = c;
         e.vld  = 1'b1;
         e.wrap = (s.pos == n*hold - 1);
         s.pos  = (s.pos + 1) % (n*hold);
      end
      e.dout = s.dout;
      e.dsel = s.dsel;
   endtask

   task automatic step();
      exp_t e;
      model(4, 2, ifa.mode, ifa.en, int'(ifa.sel), ifa.din, sa, e);
      qa.push_back(e);
      model(3, 1, ifb.mode, ifb.en, int'(ifb.sel), {4'h0, ifb.din}, sb, e);
      qb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string tag, input logic vld, input logic [3:0] d,
                      input logic [1:0] s, input logic w, input exp_t e);
      check({tag, "_vld"},  32'(vld), 32'(e.vld));
      check({tag, "_dout"}, 32'(d),   32'(e.dout));
      check({tag, "_sel"},  32'(s),   e.dsel);
      check({tag, "_wrap"}, 32'(w),   32'(e.wrap));
   endtask

   // monitor: every post-edge output is matched against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n && qa.size() > 0) begin
            e = qa.pop_front();
            cmp("mon_a", ifa.dout_vld, ifa.dout, ifa.dout_sel, ifa.wrap, e);
         end
         if (rst_n && qb.size() > 0) begin
            e = qb.pop_front();
            cmp("mon_b", ifb.dout_vld, ifb.dout, ifb.dout_sel, ifb.wrap, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [3:0] man_dout [4];
      logic [1:0] sw_sel   [10];
      logic [3:0] sw_dout  [10];
      man_dout = '{4'h3, 4'hA, 4'h5, 4'hD};
      sw_sel   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
      sw_dout  = '{4'h3, 4'h3, 4'hA, 4'hA, 4'h5, 4'h5, 4'hD, 4'hD, 4'h3, 4'h3};
      sa = '{dout: 4'h0, dsel: 0, pos: 0};
      sb = '{dout: 4'h0, dsel: 0, pos: 0};

      rst_n    = 1'b0;
      ifa.din  = 16'hD5A3;
      ifa.mode = 1'b0;
      ifa.en   = 1'b1;
      ifa.sel  = 2'd1;
      ifb.din  = 12'h5A3;
      ifb.mode = 1'b0;
      ifb.en   = 1'b0;
      ifb.sel  = 2'd0;

      // reset holds all outputs at zero even with active inputs
      repeat (3) @(posedge clk);
      #3;
      check("rst_a_dout", 32'(ifa.dout), 32'h0);
      check("rst_a_sel",  32'(ifa.dout_sel), 32'h0);
      check("rst_a_vld",  32'(ifa.dout_vld), 32'h0);
      check("rst_a_wrap", 32'(ifa.wrap), 32'h0);
      check("rst_b_vld",  32'(ifb.dout_vld), 32'h0);
      rst_n = 1'b1;

      // manual select 0..3
      for (int k = 0; k < 4; k++) begin
         ifa.sel = 2'(k);
         step();
         check("man_dout", 32'(ifa.dout), 32'(man_dout[k]));
         check("man_sel",  32'(ifa.dout_sel), k);
         check("man_vld",  32'(ifa.dout_vld), 32'h1);
      end

      // scan sweep, HOLD=2
      ifa.mode = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("sweep_sel",  32'(ifa.dout_sel), 32'(sw_sel[i]));
         check("sweep_dout", 32'(ifa.dout), 32'(sw_dout[i]));
         check("sweep_wrap", 32'(ifa.wrap), (i == 7) ? 32'h1 : 32'h0);
      end

      // restart scan, pause after first channel-1 sample
      ifa.mode = 1'b0;
      ifa.sel  = 2'd0;
      step();
      ifa.mode = 1'b1;
      repeat (3) step();
      check("pre_pause_sel", 32'(ifa.dout_sel), 32'h1);
      ifa.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("pause_vld",  32'(ifa.dout_vld), 32'h0);
         check("pause_dout", 32'(ifa.dout), 32'hA);
      end
      ifa.en = 1'b1;
      step();
      check("resume_sel1", 32'(ifa.dout_sel), 32'h1);
      step();
      check("resume_sel2", 32'(ifa.dout_sel), 32'h2);

      // manual detour at channel 2 then back to scan from channel 0
      ifa.mode = 1'b0;
      ifa.sel  = 2'd3;
      step();
      ifa.mode = 1'b1;
      step();
      check("rescan_sel0a", 32'(ifa.dout_sel), 32'h0);
      step();
      check("rescan_sel0b", 32'(ifa.dout_sel), 32'h0);
      step();
      check("rescan_sel1", 32'(ifa.dout_sel), 32'h1);

      // asynchronous reset mid-scan, checked before the next edge
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_dout", 32'(ifa.dout), 32'h0);
      check("async_rst_sel",  32'(ifa.dout_sel), 32'h0);
      check("async_rst_vld",  32'(ifa.dout_vld), 32'h0);
      sa = '{dout: 4'h0, dsel: 0, pos: 0};
      sb = '{dout: 4'h0, dsel: 0, pos: 0};
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // N=3, HOLD=1 scan and out-of-range manual select
      ifa.en   = 1'b0;
      ifb.mode = 1'b1;
      ifb.en   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("n3_sel",  32'(ifb.dout_sel), i % 3);
         check("n3_wrap", 32'(ifb.wrap), (i == 2) ? 32'h1 : 32'h0);
      end
      ifb.mode = 1'b0;
      ifb.sel  = 2'd3;
      step();
      check("n3_bad_sel_vld",  32'(ifb.dout_vld), 32'h0);
      check("n3_bad_sel_dout", 32'(ifb.dout), 32'h3);

      // randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         ifa.din  = 16'($urandom);
         ifa.mode = ($urandom_range(0, 3) != 0);
         ifa.en   = ($urandom_range(0, 3) != 0);
         ifa.sel  = 2'($urandom_range(0, 3));
         ifb.din  = 12'($urandom);
         ifb.mode = ($urandom_range(0, 3) != 0);
         ifb.en   = ($urandom_range(0, 3) != 0);
         ifb.sel  = 2'($urandom_range(0, 3));
         step();
      end

      #5;
      check("drain_a", 32'(qa.size()), 32'h0);
      check("drain_b", 32'(qb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
